// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the Mini SRC control path: opcodes, sequencer state
// encoding, ALU-op codes and the instruction classes the sequencer branches on.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  typedef enum logic [3:0] {
    ST_RESET  = 4'd0,
    ST_T0     = 4'd1,
    ST_T1     = 4'd2,
    ST_T2     = 4'd3,
    ST_T3     = 4'd4,
    ST_T4     = 4'd5,
    ST_T5     = 4'd6,
    ST_T6     = 4'd7,
    ST_T7     = 4'd8,
    ST_HALTED = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    CL_LD      = 3'd0,
    CL_LDI     = 3'd1,
    CL_ST      = 3'd2,
    CL_RTYPE   = 3'd3,
    CL_ITYPE   = 3'd4,
    CL_NOP     = 3'd5,
    CL_HALT    = 3'd6,
    CL_ILLEGAL = 3'd7
  } iclass_t;

  // Immediate forms reuse the ALU operation of their register-register twin.
  function automatic logic [4:0] itype_alu_op(input logic [4:0] op);
    logic [4:0] alu;
    case (op)
      OP_ADDI: alu = ALU_ADD;
      OP_ANDI: alu = ALU_AND;
      OP_ORI:  alu = ALU_OR;
      default: alu = 5'b00000;
    endcase
    return alu;
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational map from the IR opcode field to the instruction class that
// selects the execute-step sequence.
module instr_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] op_i,
  output iclass_t    iclass_o
);

  // Opcode to class lookup; anything not listed is illegal and ends like nop.
  always_comb begin
    iclass_o = CL_ILLEGAL;
    case (op_i)
      OP_LD:                          iclass_o = CL_LD;
      OP_LDI:                         iclass_o = CL_LDI;
      OP_ST:                          iclass_o = CL_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR:  iclass_o = CL_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:       iclass_o = CL_ITYPE;
      OP_NOP:                         iclass_o = CL_NOP;
      OP_HALT:                        iclass_o = CL_HALT;
      default:                        iclass_o = CL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Mini SRC sequencer: fetch T0-T2, per-class execute T3-T7, and a Moore decode
// of state plus IR opcode onto every datapath control line.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int W_OP = 5
) (
  input  logic            Clock,
  input  logic            clear,
  input  logic [31:0]     IR,
  input  logic            Stop,
  output logic            Run,
  output logic            PCout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            Cout,
  output logic            PCin,
  output logic            IRin,
  output logic            MARin,
  output logic            MDRin,
  output logic            Yin,
  output logic            Zin,
  output logic            IncPC,
  output logic            Read,
  output logic            Write,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic [W_OP-1:0] opcode
);

  state_t     state_q, state_d;
  logic       rel_q, rel_d;
  iclass_t    iclass_s;
  logic [4:0] ir_op_s;
  logic [4:0] alu_op_s;
  state_t     end_state_s;

  assign ir_op_s = IR[31:27];

  instr_class_decode u_decode (
    .op_i     (ir_op_s),
    .iclass_o (iclass_s)
  );

  // rel_q holds RESET for one extra edge after clear releases, so the first
  // T0 lands on the second rising edge.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q <= ST_RESET;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
    end
  end

  // Next-state sequencing.
  always_comb begin
    rel_d       = 1'b1;
    end_state_s = Stop ? ST_HALTED : ST_T0;
    state_d     = state_q;
    case (state_q)
      ST_RESET: begin
        if (rel_q) state_d = ST_T0;
        else       state_d = ST_RESET;
      end
      ST_T0: state_d = ST_T1;
      ST_T1: state_d = ST_T2;
      ST_T2: begin
        case (iclass_s)
          CL_HALT:            state_d = ST_HALTED;
          CL_NOP, CL_ILLEGAL: state_d = end_state_s;
          default:            state_d = ST_T3;
        endcase
      end
      ST_T3: state_d = ST_T4;
      ST_T4: state_d = ST_T5;
      ST_T5: begin
        case (iclass_s)
          CL_LD, CL_ST: state_d = ST_T6;
          default:      state_d = end_state_s;
        endcase
      end
      ST_T6:     state_d = ST_T7;
      ST_T7:     state_d = end_state_s;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RESET;
    endcase
  end

  // Control-line decode; every line idles low unless its step claims it.
  always_comb begin
    Run = 1'b0;  PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout = 1'b0;
    PCin = 1'b0; IRin = 1'b0;  MARin = 1'b0;   MDRin = 1'b0;  Yin = 1'b0;
    Zin = 1'b0;  IncPC = 1'b0; Read = 1'b0;    Write = 1'b0;  Gra = 1'b0;
    Grb = 1'b0;  Grc = 1'b0;   Rin = 1'b0;     Rout = 1'b0;   BAout = 1'b0;
    alu_op_s = 5'b00000;
    case (state_q)
      ST_T0: begin
        Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      ST_T1: begin
        Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      ST_T2: begin
        Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
      end
      ST_T3: begin
        Run = 1'b1;
        case (iclass_s)
          CL_LD, CL_LDI, CL_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          CL_RTYPE, CL_ITYPE:   begin Grb = 1'b1; Rout = 1'b1;  Yin = 1'b1; end
          default: ;
        endcase
      end
      ST_T4: begin
        Run = 1'b1;
        case (iclass_s)
          CL_LD, CL_LDI, CL_ST: begin Cout = 1'b1; alu_op_s = ALU_ADD; Zin = 1'b1; end
          CL_RTYPE: begin Grc = 1'b1; Rout = 1'b1; alu_op_s = ir_op_s; Zin = 1'b1; end
          CL_ITYPE: begin Cout = 1'b1; alu_op_s = itype_alu_op(ir_op_s); Zin = 1'b1; end
          default: ;
        endcase
      end
      ST_T5: begin
        Run = 1'b1;
        case (iclass_s)
          CL_LD, CL_ST:                 begin Zlowout = 1'b1; MARin = 1'b1; end
          CL_LDI, CL_RTYPE, CL_ITYPE:   begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      ST_T6: begin
        Run = 1'b1;
        case (iclass_s)
          CL_LD:   begin Read = 1'b1; MDRin = 1'b1; end
          CL_ST:   begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          default: ;
        endcase
      end
      ST_T7: begin
        Run = 1'b1;
        case (iclass_s)
          CL_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CL_ST:   Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign opcode = W_OP'(alu_op_s);

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: per-instruction step tables,
// reset behaviour, Stop handling and halt.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        clear;
  logic [31:0] IR;
  logic        Stop;
  logic Run, PCout, Zlowout, MDRout, Cout, PCin, IRin, MARin, MDRin, Yin, Zin;
  logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0] opcode;

  int checks = 0;
  int errors = 0;

  control_unit #(.W_OP(5)) dut (
    .Clock(Clock), .clear(clear), .IR(IR), .Stop(Stop), .Run(Run),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
    .Zin(Zin), .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra),
    .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .opcode(opcode)
  );

  always #5 Clock = ~Clock;

  localparam logic [19:0] RUN = 20'h80000, PCOUT = 20'h40000, ZLO = 20'h20000;
  localparam logic [19:0] MDROUT = 20'h10000, COUT = 20'h08000, PCIN = 20'h04000;
  localparam logic [19:0] IRIN = 20'h02000, MARIN = 20'h01000, MDRIN = 20'h00800;
  localparam logic [19:0] YIN = 20'h00400, ZIN = 20'h00200, INCPC = 20'h00100;
  localparam logic [19:0] READ = 20'h00080, WRITE = 20'h00040, GRA = 20'h00020;
  localparam logic [19:0] GRB = 20'h00010, GRC = 20'h00008, RIN = 20'h00004;
  localparam logic [19:0] ROUT = 20'h00002, BAOUT = 20'h00001;

  localparam logic [19:0] F_T0 = RUN | PCOUT | MARIN | INCPC | ZIN;
  localparam logic [19:0] F_T1 = RUN | ZLO | PCIN | READ | MDRIN;
  localparam logic [19:0] F_T2 = RUN | MDROUT | IRIN;

  logic [24:0] obs;
  assign obs = {Run, PCout, Zlowout, MDRout, Cout, PCin, IRin, MARin, MDRin, Yin,
                Zin, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, opcode};

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  // Walks one instruction from an observed T0 to the next observed T0/HALTED.
  task automatic run_instr(input string nm, input logic [31:0] ir, input int n,
                           input logic [19:0] ev[8], input logic [4:0] eo[8],
                           input logic [24:0] after);
    IR = ir;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs !== {ev[i], eo[i]}) begin
        errors++;
        $display("FAIL %s T%0d: got %h expected %h", nm, i, obs, {ev[i], eo[i]});
      end
      checks++;
      if ((Read & Write) !== 1'b0) begin
        errors++;
        $display("FAIL %s T%0d read_write_overlap: got R=%b W=%b", nm, i, Read, Write);
      end
      step();
    end
    checks++;
    if (obs !== after) begin
      errors++;
      $display("FAIL %s end_state: got %h expected %h", nm, obs, after);
    end
  endtask

  task automatic test_reset();
    clear = 1'b0; Stop = 1'b0; IR = 32'h0080_0055;
    #1;
    checks++;
    if (obs !== 25'd0) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", obs, 25'd0);
    end
    @(negedge Clock); @(negedge Clock);
    clear = 1'b1;
    step();
    checks++;
    if (obs !== 25'd0) begin
      errors++;
      $display("FAIL reset_first_edge: got %h expected %h", obs, 25'd0);
    end
    step();
    checks++;
    if (obs !== {F_T0, 5'b00000}) begin
      errors++;
      $display("FAIL reset_second_edge_t0: got %h expected %h", obs, {F_T0, 5'b00000});
    end
  endtask

  task automatic test_ld();
    logic [19:0] ev[8] = '{F_T0, F_T1, F_T2, RUN|GRB|BAOUT|YIN, RUN|COUT|ZIN,
                           RUN|ZLO|MARIN, RUN|READ|MDRIN, RUN|MDROUT|GRA|RIN};
    logic [4:0]  eo[8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0, 5'd0};
    run_instr("ld", 32'h0080_0055, 8, ev, eo, {F_T0, 5'b00000});
  endtask

  task automatic test_rtype();
    logic [19:0] ev[8] = '{F_T0, F_T1, F_T2, RUN|GRB|ROUT|YIN, RUN|GRC|ROUT|ZIN,
                           RUN|ZLO|GRA|RIN, 20'd0, 20'd0};
    logic [4:0]  eo[8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0, 5'd0};
    run_instr("add", 32'h1A92_0000, 6, ev, eo, {F_T0, 5'b00000});
    eo[4] = 5'b00100;
    run_instr("sub", 32'h2000_0000, 6, ev, eo, {F_T0, 5'b00000});
  endtask

  task automatic test_itype();
    logic [19:0] ev[8] = '{F_T0, F_T1, F_T2, RUN|GRB|ROUT|YIN, RUN|COUT|ZIN,
                           RUN|ZLO|GRA|RIN, 20'd0, 20'd0};
    logic [4:0]  eo[8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0, 5'd0};
    run_instr("addi", 32'h6000_0000, 6, ev, eo, {F_T0, 5'b00000});
    eo[4] = 5'b00101;
    run_instr("andi", 32'h6800_0000, 6, ev, eo, {F_T0, 5'b00000});
    eo[4] = 5'b00110;
    run_instr("ori", 32'h7000_0000, 6, ev, eo, {F_T0, 5'b00000});
  endtask

  task automatic test_ldi_st();
    logic [19:0] ev[8] = '{F_T0, F_T1, F_T2, RUN|GRB|BAOUT|YIN, RUN|COUT|ZIN,
                           RUN|ZLO|GRA|RIN, 20'd0, 20'd0};
    logic [4:0]  eo[8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0, 5'd0};
    run_instr("ldi", 32'h0880_0010, 6, ev, eo, {F_T0, 5'b00000});
    ev[5] = RUN | ZLO | MARIN;
    ev[6] = RUN | GRA | ROUT | MDRIN;
    ev[7] = RUN | WRITE;
    run_instr("st", 32'h1318_0090, 8, ev, eo, {F_T0, 5'b00000});
  endtask

  task automatic test_nop_illegal();
    logic [19:0] ev[8] = '{F_T0, F_T1, F_T2, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0};
    logic [4:0]  eo[8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    run_instr("nop", 32'hD000_0000, 3, ev, eo, {F_T0, 5'b00000});
    run_instr("illegal", 32'hF800_0000, 3, ev, eo, {F_T0, 5'b00000});
  endtask

  task automatic test_clear_mid();
    IR = 32'h0080_0055;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (obs !== {RUN | ZLO | MARIN, 5'b00000}) begin
      errors++;
      $display("FAIL clear_mid_in_t5: got %h expected %h", obs, {RUN | ZLO | MARIN, 5'b00000});
    end
    clear = 1'b0;
    #1;
    checks++;
    if (obs !== 25'd0) begin
      errors++;
      $display("FAIL clear_mid_async: got %h expected %h", obs, 25'd0);
    end
    @(negedge Clock);
    clear = 1'b1;
    step();
    checks++;
    if (obs !== 25'd0) begin
      errors++;
      $display("FAIL clear_mid_first_edge: got %h expected %h", obs, 25'd0);
    end
    step();
    checks++;
    if (obs !== {F_T0, 5'b00000}) begin
      errors++;
      $display("FAIL clear_mid_second_edge: got %h expected %h", obs, {F_T0, 5'b00000});
    end
  endtask

  task automatic test_stop();
    logic [19:0] ev[8] = '{F_T0, F_T1, F_T2, RUN|GRB|ROUT|YIN, RUN|GRC|ROUT|ZIN,
                           RUN|ZLO|GRA|RIN, 20'd0, 20'd0};
    logic [4:0]  eo[8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'd0, 5'd0, 5'd0};
    IR = 32'h1A92_0000;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) Stop = 1'b1;
      checks++;
      if (obs !== {ev[i], eo[i]}) begin
        errors++;
        $display("FAIL stop_add T%0d: got %h expected %h", i, obs, {ev[i], eo[i]});
      end
      step();
    end
    checks++;
    if (obs !== 25'd0) begin
      errors++;
      $display("FAIL stop_halted: got %h expected %h", obs, 25'd0);
    end
    Stop = 1'b0;
    clear = 1'b0;
    @(negedge Clock);
    clear = 1'b1;
    step();
    step();
    checks++;
    if (obs !== {F_T0, 5'b00000}) begin
      errors++;
      $display("FAIL stop_restart_t0: got %h expected %h", obs, {F_T0, 5'b00000});
    end
  endtask

  task automatic test_halt();
    logic [19:0] ev[8] = '{F_T0, F_T1, F_T2, 20'd0, 20'd0, 20'd0, 20'd0, 20'd0};
    logic [4:0]  eo[8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    run_instr("nop_before_halt", 32'hD000_0000, 3, ev, eo, {F_T0, 5'b00000});
    run_instr("halt", 32'hD800_0000, 3, ev, eo, 25'd0);
    for (int i = 0; i < 20; i++) begin
      Stop = i[0];
      IR = (i < 10) ? 32'h1A92_0000 : 32'h0080_0055;
      step();
      checks++;
      if (obs !== 25'd0) begin
        errors++;
        $display("FAIL halt_hold cycle %0d: got %h expected %h", i, obs, 25'd0);
      end
    end
    Stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ld();
    test_rtype();
    test_itype();
    test_ldi_st();
    test_nop_illegal();
    test_clear_mid();
    test_stop();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
